// File: rtl/prenc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prenc_pkg
//  Description : Shared types and helpers for the pair-grouped priority
//                encoder/arbiter: result struct, index-width function and
//                arbitration mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package prenc_pkg;

    // Widest pair index the result struct can carry (NPAIRS up to 256).
    localparam int IDX_MAX_W = 8;

    // rr_mode encodings.
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Outcome of one pair scan. conflict marks a deciding pair with both bits set.
    typedef struct packed {
        logic                 v;
        logic [IDX_MAX_W-1:0] idx;
        logic                 sel;
        logic                 conflict;
    } prenc_res_t;

    // Index width for a given pair count; never narrower than one bit.
    function automatic int prenc_idx_w(input int npairs);
        if (npairs <= 2) begin
            return 1;
        end
        return $clog2(npairs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prenc_pair_find.sv
`default_nettype none
// ============================================================================
//  Module      : prenc_pair_find
//  Description : Combinational pair scanner. Starting at i_start and walking
//                downward with wrap-around, the first pair with any bit set
//                decides the result; both bits set yields a conflict.
//  Revision    : 1.0 - initial release
// ============================================================================
module prenc_pair_find
    import prenc_pkg::*;
#(
    parameter int NPAIRS = 3
) (
    input  logic [2*NPAIRS-1:0]  i_req,
    input  logic [IDX_MAX_W-1:0] i_start,
    output prenc_res_t           o_res
);

    logic w_found;
    int   w_k;

    // Walk pairs from i_start down (mod NPAIRS); the first non-empty pair wins.
    always_comb begin
        o_res   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 0; i < NPAIRS; i++) begin
            w_k = (int'(i_start) + NPAIRS - i) % NPAIRS;
            if (!w_found && (i_req[2*w_k +: 2] != 2'b00)) begin
                w_found   = 1'b1;
                o_res.idx = IDX_MAX_W'(w_k);
                if (i_req[2*w_k +: 2] == 2'b11) begin
                    // Both bits requested: illegal encode, lower pairs masked.
                    o_res.conflict = 1'b1;
                end else begin
                    o_res.v   = 1'b1;
                    o_res.sel = i_req[2*w_k+1];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prenc_pair_arb.sv
`default_nettype none
// ============================================================================
//  Module      : prenc_pair_arb
//  Description : Registered pair-grouped priority encoder with fixed or
//                round-robin pair order and a one-entry valid/ready output
//                register. Define PRENC_CONFLICT_CNT_EN to add the clr_cnt
//                input, conflict_cnt output and saturating conflict counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module prenc_pair_arb
    import prenc_pkg::*;
#(
    parameter int NPAIRS = 3,
`ifdef PRENC_CONFLICT_CNT_EN
    parameter int CNT_W  = 8,
`endif
    // Derived from NPAIRS; leave at its default.
    parameter int IDX_W  = prenc_idx_w(NPAIRS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*NPAIRS-1:0] req,
    input  logic                rr_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_v,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_sel
`ifdef PRENC_CONFLICT_CNT_EN
    ,
    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    conflict_cnt
`endif
);

    logic                 r_out_valid;
    logic                 r_out_v;
    logic [IDX_W-1:0]     r_out_idx;
    logic                 r_out_sel;
    logic [IDX_MAX_W-1:0] r_last_idx;
    logic [IDX_MAX_W-1:0] w_start;
    logic                 w_accept;
    logic                 w_legal;
    prenc_res_t           w_res;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    // A conflict never counts as a legal encode.
    assign w_legal   = w_res.v && !w_res.conflict;

    assign out_valid = r_out_valid;
    assign out_v     = r_out_v;
    assign out_idx   = r_out_idx;
    assign out_sel   = r_out_sel;

    // Scan start: top pair in fixed mode, one below the last winner in round-robin.
    always_comb begin
        w_start = IDX_MAX_W'(NPAIRS - 1);
        case (rr_mode)
            1'(MODE_FIXED): w_start = IDX_MAX_W'(NPAIRS - 1);
            1'(MODE_RR):    w_start = (r_last_idx == '0) ? IDX_MAX_W'(NPAIRS - 1)
                                                         : r_last_idx - 1'b1;
            default:        w_start = IDX_MAX_W'(NPAIRS - 1);
        endcase
    end

    prenc_pair_find #(
        .NPAIRS (NPAIRS)
    ) u_find (
        .i_req   (req),
        .i_start (w_start),
        .o_res   (w_res)
    );

    // One-entry output register: load on accept, drop valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_v     <= 1'b0;
            r_out_idx   <= '0;
            r_out_sel   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_v     <= w_legal;
            r_out_idx   <= w_res.idx[IDX_W-1:0];
            r_out_sel   <= w_res.sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Remember the last legal winner; it becomes lowest priority in round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_idx <= '0;
        end else if (w_accept && w_legal) begin
            r_last_idx <= w_res.idx;
        end
    end

`ifdef PRENC_CONFLICT_CNT_EN
    logic [CNT_W-1:0] r_conflict_cnt;

    // Saturating count of accepted conflicts; clear takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (clr_cnt) begin
            r_conflict_cnt <= '0;
        end else if (w_accept && w_res.conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prenc_pair_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prenc_pair_arb
//  Description : Scoreboard bench for prenc_pair_arb (NPAIRS=3). Directed
//                requests push expected results; a negedge monitor pops and
//                compares each result as it is consumed. Counter checks are
//                active when PRENC_CONFLICT_CNT_EN is defined (CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prenc_pair_arb;

    typedef struct packed {
        logic       v;
        logic [1:0] idx;
        logic       sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] req;
    logic       rr_mode;
    logic       out_valid;
    logic       out_ready;
    logic       out_v;
    logic [1:0] out_idx;
    logic       out_sel;
`ifdef PRENC_CONFLICT_CNT_EN
    logic       clr_cnt;
    logic [1:0] conflict_cnt;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t m_exp;

    prenc_pair_arb #(
`ifdef PRENC_CONFLICT_CNT_EN
        .CNT_W     (2),
`endif
        .NPAIRS    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .req       (req),
        .rr_mode   (rr_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_v     (out_v),
        .out_idx   (out_idx),
        .out_sel   (out_sel)
`ifdef PRENC_CONFLICT_CNT_EN
        ,
        .clr_cnt      (clr_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every consumed result is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got v=%0d idx=%0d sel=%0d expected no output",
                         out_v, out_idx, out_sel);
            end else begin
                m_exp = sb_q.pop_front();
                check("sb_out_v",   int'(out_v),   int'(m_exp.v));
                check("sb_out_idx", int'(out_idx), int'(m_exp.idx));
                check("sb_out_sel", int'(out_sel), int'(m_exp.sel));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait (bounded) for acceptance, record the expectation.
    task automatic send(input logic [5:0] r, input logic m,
                        input logic ev, input logic [1:0] ei, input logic es);
        exp_t e;
        int   waited;
        waited   = 0;
        in_valid = 1'b1;
        req      = r;
        rr_mode  = m;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.v   = ev;
        e.idx = ei;
        e.sel = es;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        req       = '0;
        rr_mode   = 1'b0;
        out_ready = 1'b1;
`ifdef PRENC_CONFLICT_CNT_EN
        clr_cnt   = 1'b0;
`endif
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_v",     int'(out_v),     0);
        check("rst_out_idx",   int'(out_idx),   0);
        check("rst_out_sel",   int'(out_sel),   0);
`ifdef PRENC_CONFLICT_CNT_EN
        check("rst_cnt",       int'(conflict_cnt), 0);
`endif
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("rst_in_ready", int'(in_ready), 1);

        // Fixed priority
        send(6'b100000, 1'b0, 1'b1, 2'd2, 1'b1);
        send(6'b011000, 1'b0, 1'b1, 2'd2, 1'b0);  // pair 2 holds only bit 4
        send(6'b001100, 1'b0, 1'b0, 2'd1, 1'b0);  // pair 1 conflict
`ifdef PRENC_CONFLICT_CNT_EN
        check("cnt_after_conflict", int'(conflict_cnt), 1);
`endif
        send(6'b000000, 1'b0, 1'b0, 2'd0, 1'b0);
`ifdef PRENC_CONFLICT_CNT_EN
        check("cnt_after_empty", int'(conflict_cnt), 1);
`endif
        send(6'b000001, 1'b0, 1'b1, 2'd0, 1'b0);  // last_idx -> 0

        // Round-robin rotation, then back to fixed
        send(6'b010101, 1'b1, 1'b1, 2'd2, 1'b0);
        send(6'b010101, 1'b1, 1'b1, 2'd1, 1'b0);
        send(6'b010101, 1'b1, 1'b1, 2'd0, 1'b0);
        send(6'b010101, 1'b1, 1'b1, 2'd2, 1'b0);
        send(6'b010101, 1'b0, 1'b1, 2'd2, 1'b0);

        // Backpressure: hold 000010 (pair 0 upper), then release with no bubble
        tick();
        out_ready = 1'b0;
        send(6'b000010, 1'b0, 1'b1, 2'd0, 1'b1);
        in_valid = 1'b1;
        req      = 6'b000100;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready",  int'(in_ready),  0);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_out_v",     int'(out_v),     1);
            check("stall_out_idx",   int'(out_idx),   0);
            check("stall_out_sel",   int'(out_sel),   1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", int'(in_ready), 1);
        begin
            exp_t e;
            e.v = 1'b1; e.idx = 2'd1; e.sel = 1'b0;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("no_bubble_valid", int'(out_valid), 1);
        tick();

`ifdef PRENC_CONFLICT_CNT_EN
        // Saturation at 3, then clear beating a same-cycle conflict
        repeat (5) send(6'b001100, 1'b0, 1'b0, 2'd1, 1'b0);
        check("cnt_saturated", int'(conflict_cnt), 3);
        clr_cnt = 1'b1;
        send(6'b001100, 1'b0, 1'b0, 2'd1, 1'b0);
        clr_cnt = 1'b0;
        check("cnt_clear_wins", int'(conflict_cnt), 0);
        send(6'b110000, 1'b0, 1'b0, 2'd2, 1'b0);
        check("cnt_reincrement", int'(conflict_cnt), 1);
`endif

        // Reset during a stall; last_idx set to 1 first
        tick();
        out_ready = 1'b0;
        send(6'b000100, 1'b0, 1'b1, 2'd1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_v",     int'(out_v),     0);
        check("mid_rst_out_idx",   int'(out_idx),   0);
`ifdef PRENC_CONFLICT_CNT_EN
        check("mid_rst_cnt",       int'(conflict_cnt), 0);
`endif
        sb_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        tick();
        send(6'b010101, 1'b1, 1'b1, 2'd2, 1'b0);
        tick();
        tick();
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
